// File: rtl/uart_dbg_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_dbg_pkg;

  localparam int unsigned N_REQ_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 1024;
  localparam int unsigned GID_W       = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEND  = 2'd2,
    GAP   = 2'd3
  } state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx side signals of the UART transmit arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = uart_dbg_pkg::N_REQ_DEF
);

  logic [N_REQ-1:0]                req_valid;
  logic [8*N_REQ-1:0]              req_data;
  logic [N_REQ-1:0]                req_last;
  logic [N_REQ-1:0]                req_ready;
  logic [7:0]                      tx_data;
  logic                            tx_data_valid;
  logic                            tx_data_ready;
  logic [uart_dbg_pkg::GID_W-1:0]  grant_id;
  logic                            busy;
  logic [7:0]                      timeout_count;

  // Arbiter side
  modport master (
    input  req_valid, req_data, req_last, tx_data_ready,
    output req_ready, tx_data, tx_data_valid, grant_id, busy, timeout_count
  );

  // Requester / uart_tx / observer side
  modport slave (
    output req_valid, req_data, req_last, tx_data_ready,
    input  req_ready, tx_data, tx_data_valid, grant_id, busy, timeout_count
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after i_last, wrapping.
module rr_pick
  import uart_dbg_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [GID_W-1:0] i_last,
  output logic [GID_W-1:0] o_win,
  output logic             o_found
);

  logic [7:0] w_req8;

  assign w_req8 = 8'(i_req);

  // Scan farthest-first so the nearest requester after i_last wins.
  always_comb begin
    logic [GID_W-1:0] idx;
    o_win   = i_last;
    o_found = 1'b0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      idx = GID_W'((32'(i_last) + k) % N_REQ);
      if (w_req8[idx]) begin
        o_win   = idx;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-atomic arbiter sharing one uart_tx between N_REQ byte requesters.
module uart_tx_arbiter
  import uart_dbg_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input logic               clk,
  input logic               rst_n,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e           r_state, w_state_nxt;
  logic [GID_W-1:0] r_gid, r_last_owner, w_pick;
  logic             w_found, r_busy, r_hold_last;
  logic [7:0]       r_hold_data, r_tocnt;
  logic [7:0]       w_valid8, w_last8, w_ready8;
  logic [63:0]      w_data64;
  logic [CNT_W-1:0] r_idle_cnt;
  logic             w_start, w_capture, w_idle_tick, w_revoke, w_finish;

  assign w_valid8 = 8'(bus.req_valid);
  assign w_last8  = 8'(bus.req_last);
  assign w_data64 = 64'(bus.req_data);
  assign w_ready8 = (r_state == GRANT) ? (8'd1 << r_gid) : 8'd0;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req   (bus.req_valid),
    .i_last  (r_last_owner),
    .o_win   (w_pick),
    .o_found (w_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus one-cycle control strobes for the datapath.
  always_comb begin
    w_state_nxt       = r_state;
    w_start           = 1'b0;
    w_capture         = 1'b0;
    w_idle_tick       = 1'b0;
    w_revoke          = 1'b0;
    w_finish          = 1'b0;
    bus.tx_data_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_start     = 1'b1;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (w_valid8[r_gid]) begin
          w_capture   = 1'b1;
          w_state_nxt = SEND;
        end else if (r_idle_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_revoke    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_idle_tick = 1'b1;
        end
      end
      SEND: begin
        if (bus.tx_data_ready) begin
          bus.tx_data_valid = 1'b1;
          w_state_nxt       = GAP;
        end
      end
      GAP: begin
        w_finish    = r_hold_last;
        w_state_nxt = r_hold_last ? IDLE : GRANT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gid        <= '0;
      r_last_owner <= GID_W'(N_REQ - 1);
      r_busy       <= 1'b0;
      r_hold_data  <= '0;
      r_hold_last  <= 1'b0;
      r_idle_cnt   <= '0;
      r_tocnt      <= '0;
    end else begin
      if (w_start) begin
        r_gid  <= w_pick;
        r_busy <= 1'b1;
      end
      if (w_capture) begin
        r_hold_data <= w_data64[{r_gid, 3'b000} +: 8];
        r_hold_last <= w_last8[r_gid];
      end
      if (w_capture || w_revoke)  r_idle_cnt <= '0;
      else if (w_idle_tick)       r_idle_cnt <= r_idle_cnt + CNT_W'(1);
      if (w_finish || w_revoke) begin
        r_busy       <= 1'b0;
        r_last_owner <= r_gid;
      end
      // Revoked grants saturate rather than wrap.
      if (w_revoke && (r_tocnt != 8'hFF)) r_tocnt <= r_tocnt + 8'd1;
    end
  end

  assign bus.req_ready     = N_REQ'(w_ready8);
  assign bus.tx_data       = r_hold_data;
  assign bus.grant_id      = r_gid;
  assign bus.busy          = r_busy;
  assign bus.timeout_count = r_tocnt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(NR)) bus ();

  uart_tx_arbiter #(.N_REQ(NR), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          strobes = 0;
  int          strobe_cyc = 0;
  int          last_strobe = -1;
  bit          chk_gap = 1'b0;
  logic        tx_rdy = 1'b1;
  logic [NR-1:0] hs;
  logic [8:0]  src_q [NR][$];
  logic [10:0] exp_q [$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requester and uart_tx models, updated on the falling edge.
  initial begin
    logic [8:0] h;
    bus.req_valid     = '0;
    bus.req_data      = '0;
    bus.req_last      = '0;
    bus.tx_data_ready = 1'b1;
    hs                = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < int'(NR); i++) begin
        if (!rst_n) hs[i] = 1'b0;
        if (hs[i] && (src_q[i].size() > 0)) void'(src_q[i].pop_front());
        bus.req_valid[i] = rst_n && (src_q[i].size() > 0);
        if (src_q[i].size() > 0) begin
          h = src_q[i][0];
          bus.req_data[8*i +: 8] = h[7:0];
          bus.req_last[i]        = h[8];
        end else begin
          bus.req_data[8*i +: 8] = 8'h00;
          bus.req_last[i]        = 1'b0;
        end
      end
      bus.tx_data_ready = tx_rdy;
      hs = bus.req_ready & bus.req_valid;
    end
  end

  // Output monitor: strobes are popped against the scoreboard.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        checks++;
        assert ($onehot0(bus.req_ready) === 1'b1) else begin
          errors++;
          $error("FAIL ready_onehot got=%b exp=onehot0", bus.req_ready);
        end
        if (bus.tx_data_ready === 1'b0) begin
          checks++;
          assert (bus.tx_data_valid === 1'b0) else begin
            errors++;
            $error("FAIL valid_without_ready got=%b exp=0", bus.tx_data_valid);
          end
        end
        if (bus.tx_data_valid === 1'b1) begin
          strobes++;
          strobe_cyc = cyc;
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_strobe got=%02h exp=none", bus.tx_data);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (bus.tx_data === e[7:0]) else begin
              errors++;
              $error("FAIL tx_data got=%02h exp=%02h", bus.tx_data, e[7:0]);
            end
            checks++;
            assert (bus.grant_id === e[10:8]) else begin
              errors++;
              $error("FAIL strobe_owner got=%0d exp=%0d", bus.grant_id, e[10:8]);
            end
          end
          if (chk_gap && (last_strobe >= 0)) begin
            checks++;
            assert ((cyc - last_strobe) === 3) else begin
              errors++;
              $error("FAIL byte_spacing got=%0d exp=3", cyc - last_strobe);
            end
          end
          last_strobe = cyc;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] b, input logic last, input bit scb);
    src_q[r].push_back({last, b});
    if (scb) exp_q.push_back({3'(r), b});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(bus.tx_data_valid), 32'd0);
    chk({tag, "_data"},  32'(bus.tx_data),       32'd0);
    chk({tag, "_ready"}, 32'(bus.req_ready),     32'd0);
    chk({tag, "_gid"},   32'(bus.grant_id),      32'd0);
    chk({tag, "_busy"},  32'(bus.busy),          32'd0);
    chk({tag, "_tocnt"}, 32'(bus.timeout_count), 32'd0);
  endtask

  task automatic clear_queues();
    for (int i = 0; i < int'(NR); i++) src_q[i].delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    chk_gap = 1'b0;
    tx_rdy  = 1'b1;
    clear_queues();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (((exp_q.size() != 0) || (bus.busy !== 1'b0)) && (n < budget)) begin
      step();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL %s_wait got=%0d cycles exp=<%0d", tag, n, budget);
    end
  endtask

  initial begin
    int s0;
    int n;
    int d;

    // Reset state
    step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();

    // Single message "OK\r\n", 3-cycle byte spacing
    do_reset();
    chk_gap     = 1'b1;
    last_strobe = -1;
    s0          = strobes;
    push_byte(0, 8'h4F, 1'b0, 1'b1);
    push_byte(0, 8'h4B, 1'b0, 1'b1);
    push_byte(0, 8'h0D, 1'b0, 1'b1);
    push_byte(0, 8'h0A, 1'b1, 1'b1);
    wait_done("single", 100);
    chk("single_count", 32'(strobes - s0), 32'd4);
    chk("single_busy",  32'(bus.busy),     32'd0);
    chk("single_gid",   32'(bus.grant_id), 32'd0);
    chk_gap = 1'b0;

    // Contention: requester 1 then requester 2, no interleave
    do_reset();
    push_byte(1, 8'hA1, 1'b0, 1'b1);
    push_byte(1, 8'hA2, 1'b0, 1'b1);
    push_byte(1, 8'hA3, 1'b1, 1'b1);
    push_byte(2, 8'hB1, 1'b0, 1'b1);
    push_byte(2, 8'hB2, 1'b1, 1'b1);
    step();
    step();
    chk("cont_first_gid",  32'(bus.grant_id), 32'd1);
    chk("cont_first_busy", 32'(bus.busy),     32'd1);
    wait_done("contention", 200);
    chk("cont_last_gid", 32'(bus.grant_id), 32'd2);

    // Fairness: single-byte messages from all requesters
    do_reset();
    for (int rd = 0; rd < 2; rd++)
      for (int r = 0; r < int'(NR); r++)
        push_byte(r, 8'(16 * r + rd), 1'b1, 1'b1);
    wait_done("fair", 300);
    chk("fair_last_gid", 32'(bus.grant_id), 32'd3);

    // Timeout: owner stalls mid-message, requester 1 granted next
    do_reset();
    s0 = strobes;
    push_byte(0, 8'h55, 1'b0, 1'b1);
    push_byte(1, 8'h66, 1'b1, 1'b1);
    n = 0;
    while ((strobes == s0) && (n < 50)) begin step(); n++; end
    chk("to_first_byte", 32'(strobes - s0), 32'd1);
    s0 = strobe_cyc;
    n  = 0;
    while ((bus.timeout_count == 8'd0) && (n < 100)) begin step(); n++; end
    d = cyc - s0;
    checks++;
    assert ((d >= 18) && (d <= 19)) else begin
      errors++;
      $error("FAIL to_latency got=%0d exp=18..19", d);
    end
    chk("to_count",      32'(bus.timeout_count), 32'd1);
    wait_done("timeout", 100);
    chk("to_next_gid",   32'(bus.grant_id),      32'd1);
    chk("to_count_hold", 32'(bus.timeout_count), 32'd1);

    // Backpressure: 500+ stalled cycles in SEND, no strobe, no timeout
    do_reset();
    tx_rdy = 1'b0;
    s0     = strobes;
    push_byte(0, 8'hA5, 1'b1, 1'b1);
    repeat (520) step();
    chk("bp_no_strobe", 32'(strobes - s0),      32'd0);
    chk("bp_busy",      32'(bus.busy),          32'd1);
    chk("bp_no_to",     32'(bus.timeout_count), 32'd0);
    tx_rdy = 1'b1;
    wait_done("backpressure", 20);
    chk("bp_emitted",   32'(strobes - s0),      32'd1);

    // Reset after 2 of 5 bytes abandons the message
    do_reset();
    s0 = strobes;
    push_byte(0, 8'hC1, 1'b0, 1'b1);
    push_byte(0, 8'hC2, 1'b0, 1'b1);
    push_byte(0, 8'hC3, 1'b0, 1'b0);
    push_byte(0, 8'hC4, 1'b0, 1'b0);
    push_byte(0, 8'hC5, 1'b1, 1'b0);
    n = 0;
    while ((strobes - s0 < 2) && (n < 50)) begin step(); n++; end
    chk("mid_two_bytes", 32'(strobes - s0), 32'd2);
    rst_n = 1'b0;
    clear_queues();
    step();
    chk_reset_vals("mid_rst");
    rst_n = 1'b1;
    repeat (40) step();
    chk("mid_no_more", 32'(strobes - s0), 32'd2);
    chk("mid_busy",    32'(bus.busy),     32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
